// File: rtl/xgmac_rx_frame_filter.sv
// Store-and-forward receive frame buffer for the 10G MAC receive stream.
// Frames are written into a block RAM. A frame becomes visible to the read
// side only after its last beat arrives without the bad-frame flag. Bad and
// overflowing frames are discarded by rewinding the write pointer to the last
// committed boundary. The read side streams committed words through a RAM
// read stage and an output register under tready flow control.
module xgmac_rx_frame_filter #(
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                   rx_clk,
    input  logic                   reset,
    input  logic [63:0]            s_axis_tdata,
    input  logic [7:0]             s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [C_CNT_WIDTH-1:0] good_frames,
    output logic [C_CNT_WIDTH-1:0] bad_frames,
    output logic [C_CNT_WIDTH-1:0] ovf_frames
);

    localparam int DEPTH = 1 << C_ADDR_WIDTH;
    localparam logic [C_ADDR_WIDTH:0] PTR_ONE   = (C_ADDR_WIDTH+1)'(1);
    localparam logic [C_ADDR_WIDTH:0] FULL_DIFF = (C_ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FRAME,
        WR_DROP
    } wr_state_t;

    // Stored word layout: {tlast, tkeep[7:0], tdata[63:0]}
    logic [72:0] mem [0:DEPTH-1];

    wr_state_t             wr_state_q, wr_state_d;
    logic [C_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_WIDTH:0] wr_start_q, wr_start_d;
    logic [C_ADDR_WIDTH:0] rd_ptr_q;
    logic                  wr_en;
    logic                  full;
    logic [2:0]            cnt_inc;   // [0]=good, [1]=bad, [2]=ovf

    logic [72:0]           rd_word_q;
    logic                  s1_valid_q;
    logic [72:0]           out_word_q;
    logic                  out_valid_q;
    logic                  avail;
    logic                  out_load;
    logic                  rd_en;

    logic [C_CNT_WIDTH-1:0] cnt_q [3];

    // The MAC cannot be stalled; overflow is handled by dropping frames.
    assign s_axis_tready = 1'b1;

    // Occupancy uses the registered read pointer, so a read in this cycle
    // does not make room for a write in the same cycle.
    assign full = (wr_ptr_q - rd_ptr_q) == FULL_DIFF;

    // Write FSM: next state, pointer updates, RAM write strobe, counter events
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_start_d = wr_start_q;
        wr_en      = 1'b0;
        cnt_inc    = 3'b000;
        if (s_axis_tvalid) begin
            case (wr_state_q)
                WR_IDLE, WR_FRAME: begin
                    if (!full) begin
                        if (!s_axis_tlast) begin
                            wr_en      = 1'b1;
                            wr_ptr_d   = wr_ptr_q + PTR_ONE;
                            wr_state_d = WR_FRAME;
                        end else if (!s_axis_tuser) begin
                            wr_en      = 1'b1;
                            wr_ptr_d   = wr_ptr_q + PTR_ONE;
                            wr_start_d = wr_ptr_q + PTR_ONE;
                            cnt_inc[0] = 1'b1;
                            wr_state_d = WR_IDLE;
                        end else begin
                            wr_ptr_d   = wr_start_q;
                            cnt_inc[1] = 1'b1;
                            wr_state_d = WR_IDLE;
                        end
                    end else begin
                        if (!s_axis_tlast) begin
                            wr_state_d = WR_DROP;
                        end else begin
                            wr_ptr_d   = wr_start_q;
                            cnt_inc[2] = 1'b1;
                            wr_state_d = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        wr_ptr_d   = wr_start_q;
                        cnt_inc[2] = 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // Write FSM state and pointer registers
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            wr_ptr_q   <= '0;
            wr_start_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_start_q <= wr_start_d;
        end
    end

    // RAM write port; a write is never issued while reset is asserted
    always_ff @(posedge rx_clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr_q[C_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Only committed words (up to wr_start) are ever read.
    assign avail    = rd_ptr_q != wr_start_q;
    assign out_load = !out_valid_q || m_axis_tready;
    assign rd_en    = avail && (!s1_valid_q || out_load);

    // RAM registered read port
    always_ff @(posedge rx_clk) begin
        if (rd_en) begin
            rd_word_q <= mem[rd_ptr_q[C_ADDR_WIDTH-1:0]];
        end
    end

    // Read pointer, read-stage valid and output register (held while stalled)
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            s1_valid_q <= rd_en || (s1_valid_q && !out_load);
            if (out_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_word_q <= rd_word_q;
                end
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_word_q[72];
    assign m_axis_tkeep  = out_word_q[71:64];
    assign m_axis_tdata  = out_word_q[63:0];

    // Saturating statistics counters, one per frame outcome
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // Increment on event, hold at all-ones
            always_ff @(posedge rx_clk) begin
                if (reset) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_q[gi] != {C_CNT_WIDTH{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + C_CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign good_frames = cnt_q[0];
    assign bad_frames  = cnt_q[1];
    assign ovf_frames  = cnt_q[2];

endmodule

// File: tb/tb_xgmac_rx_frame_filter.sv
// Directed bench for the receive frame filter, small buffer and counters.
module tb_xgmac_rx_frame_filter;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          rx_clk = 1'b0;
    logic          reset;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] good_frames;
    logic [CW-1:0] bad_frames;
    logic [CW-1:0] ovf_frames;

    int passed = 0;
    int total  = 0;

    xgmac_rx_frame_filter #(
        .C_ADDR_WIDTH(AW),
        .C_CNT_WIDTH (CW)
    ) dut (
        .rx_clk       (rx_clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .good_frames  (good_frames),
        .bad_frames   (bad_frames),
        .ovf_frames   (ovf_frames)
    );

    always #5 rx_clk = ~rx_clk;

    int cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    // Output monitor: records accepted words, counts words changed during stalls
    logic [72:0] outq [$];
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [72:0] prev_word = '0;
    always @(negedge rx_clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid ||
                ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_word)))
                stall_err <= stall_err + 1;
            if (m_axis_tvalid && m_axis_tready)
                outq.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_word  <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    function automatic logic [72:0] w(input logic l, input logic [7:0] k, input logic [63:0] d);
        return {l, k, d};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        @(posedge rx_clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge rx_clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge rx_clk);
        @(negedge rx_clk);
        total++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready_during got=%b want=1", s_axis_tready); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid_during got=%b want=0", m_axis_tvalid); else passed++;
        @(posedge rx_clk); #1;
        reset = 1'b0;
        @(negedge rx_clk);
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 64'h0) $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); else passed++;
        total++; if (m_axis_tkeep !== 8'h0) $display("FAIL reset_tkeep got=%h want=0", m_axis_tkeep); else passed++;
        total++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); else passed++;
        total++; if (good_frames !== 4'd0) $display("FAIL reset_good got=%0d want=0", good_frames); else passed++;
        total++; if (bad_frames !== 4'd0) $display("FAIL reset_bad got=%0d want=0", bad_frames); else passed++;
        total++; if (ovf_frames !== 4'd0) $display("FAIL reset_ovf got=%0d want=0", ovf_frames); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready_after got=%b want=1", s_axis_tready); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        int base, e0, first;
        logic [72:0] exp_w, got_w;
        do_reset();
        m_axis_tready = 1'b1;
        base = outq.size();
        for (int i = 0; i < 8; i++)
            send_beat(64'(i), (i == 7) ? 8'h0F : 8'hFF, i == 7, 1'b0);
        e0 = cyc;
        first = -1;
        for (int n = 0; n < 10 && first < 0; n++) begin
            @(negedge rx_clk);
            if (m_axis_tvalid) first = cyc;
        end
        total++; if (first != e0 + 2) $display("FAIL good_latency got_edge=%0d want_edge=%0d", first, e0 + 2); else passed++;
        repeat (15) @(posedge rx_clk); #1;
        total++; if (outq.size() - base != 8) $display("FAIL good_count got=%0d want=8", outq.size() - base); else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_w = w(i == 7, (i == 7) ? 8'h0F : 8'hFF, 64'(i));
            got_w = (base + i < outq.size()) ? outq[base + i] : 73'bx;
            total++; if (got_w !== exp_w) $display("FAIL good_beat%0d got=%h want=%h", i, got_w, exp_w); else passed++;
        end
        total++; if (good_frames !== 4'd1) $display("FAIL good_cnt got=%0d want=1", good_frames); else passed++;
        $display("test_good_frame done");
    endtask

    task automatic test_bad_frame();
        int base;
        logic [72:0] exp_w, got_w;
        do_reset();
        m_axis_tready = 1'b1;
        base = outq.size();
        for (int i = 0; i < 5; i++)
            send_beat(64'hB0 + 64'(i), 8'hFF, i == 4, i == 4);
        for (int i = 0; i < 3; i++)
            send_beat(64'hC0 + 64'(i), (i == 2) ? 8'h3F : 8'hFF, i == 2, 1'b0);
        repeat (12) @(posedge rx_clk); #1;
        total++; if (outq.size() - base != 3) $display("FAIL bad_count got=%0d want=3", outq.size() - base); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp_w = w(i == 2, (i == 2) ? 8'h3F : 8'hFF, 64'hC0 + 64'(i));
            got_w = (base + i < outq.size()) ? outq[base + i] : 73'bx;
            total++; if (got_w !== exp_w) $display("FAIL bad_beat%0d got=%h want=%h", i, got_w, exp_w); else passed++;
        end
        total++; if (bad_frames !== 4'd1) $display("FAIL bad_badcnt got=%0d want=1", bad_frames); else passed++;
        total++; if (good_frames !== 4'd1) $display("FAIL bad_goodcnt got=%0d want=1", good_frames); else passed++;
        total++; if (ovf_frames !== 4'd0) $display("FAIL bad_ovfcnt got=%0d want=0", ovf_frames); else passed++;
        $display("test_bad_frame done");
    endtask

    task automatic test_overflow();
        int base, se0;
        logic [72:0] exp_w, got_w;
        do_reset();
        m_axis_tready = 1'b0;
        base = outq.size();
        se0 = stall_err;
        for (int i = 0; i < 10; i++)
            send_beat(64'h100 + 64'(i), 8'hFF, i == 9, 1'b0);
        for (int i = 0; i < 10; i++)
            send_beat(64'h200 + 64'(i), 8'hFF, i == 9, 1'b0);
        repeat (5) @(posedge rx_clk);
        @(negedge rx_clk);
        total++; if (ovf_frames !== 4'd1) $display("FAIL ovf_cnt got=%0d want=1", ovf_frames); else passed++;
        total++; if (good_frames !== 4'd1) $display("FAIL ovf_goodcnt got=%0d want=1", good_frames); else passed++;
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h100)
            $display("FAIL ovf_stall_head got_valid=%b got_data=%h want_valid=1 want_data=100", m_axis_tvalid, m_axis_tdata); else passed++;
        @(posedge rx_clk); #1;
        m_axis_tready = 1'b1;
        repeat (20) @(posedge rx_clk); #1;
        total++; if (outq.size() - base != 10) $display("FAIL ovf_count got=%0d want=10", outq.size() - base); else passed++;
        for (int i = 0; i < 10; i++) begin
            exp_w = w(i == 9, 8'hFF, 64'h100 + 64'(i));
            got_w = (base + i < outq.size()) ? outq[base + i] : 73'bx;
            total++; if (got_w !== exp_w) $display("FAIL ovf_beat%0d got=%h want=%h", i, got_w, exp_w); else passed++;
        end
        total++; if (stall_err != se0) $display("FAIL ovf_stall_stable got=%0d want=0", stall_err - se0); else passed++;
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        int base, se0;
        logic [72:0] exp_w, got_w;
        do_reset();
        base = outq.size();
        se0 = stall_err;
        for (int i = 0; i < 12; i++) begin
            m_axis_tready = (i % 2) == 0;
            send_beat(64'h300 + 64'(i), 8'(i + 1), 1'b1, 1'b0);
        end
        repeat (30) begin
            m_axis_tready = ~m_axis_tready;
            @(posedge rx_clk); #1;
        end
        m_axis_tready = 1'b1;
        repeat (4) @(posedge rx_clk); #1;
        total++; if (outq.size() - base != 12) $display("FAIL b2b_count got=%0d want=12", outq.size() - base); else passed++;
        for (int i = 0; i < 12; i++) begin
            exp_w = w(1'b1, 8'(i + 1), 64'h300 + 64'(i));
            got_w = (base + i < outq.size()) ? outq[base + i] : 73'bx;
            total++; if (got_w !== exp_w) $display("FAIL b2b_beat%0d got=%h want=%h", i, got_w, exp_w); else passed++;
        end
        total++; if (stall_err != se0) $display("FAIL b2b_stall_stable got=%0d want=0", stall_err - se0); else passed++;
        total++; if (good_frames !== 4'd12) $display("FAIL b2b_goodcnt got=%0d want=12", good_frames); else passed++;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        int base;
        logic [72:0] exp_w, got_w;
        logic [72:0] expq [$];
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++)
            send_beat(64'h400 + 64'(i), 8'hFF, i == 5, 1'b0);
        for (int i = 0; i < 3; i++)
            send_beat(64'h500 + 64'(i), 8'hFF, 1'b0, 1'b0);
        @(negedge rx_clk);
        total++; if (m_axis_tvalid !== 1'b1 || good_frames !== 4'd1)
            $display("FAIL mid_pre_reset got_valid=%b got_good=%0d want_valid=1 want_good=1", m_axis_tvalid, good_frames); else passed++;
        @(posedge rx_clk); #1;
        // One reset cycle with a beat arriving that must be ignored
        reset = 1'b1;
        s_axis_tdata  = 64'h5FF;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(posedge rx_clk); #1;
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge rx_clk);
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_tvalid got=%b want=0", m_axis_tvalid); else passed++;
        total++; if (good_frames !== 4'd0) $display("FAIL mid_goodcnt got=%0d want=0", good_frames); else passed++;
        base = outq.size();
        @(posedge rx_clk); #1;
        send_beat(64'h503, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h504, 8'h07, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            send_beat(64'h600 + 64'(i), 8'hFF, i == 2, 1'b0);
        repeat (15) @(posedge rx_clk); #1;
        expq.push_back(w(1'b0, 8'hFF, 64'h503));
        expq.push_back(w(1'b1, 8'h07, 64'h504));
        expq.push_back(w(1'b0, 8'hFF, 64'h600));
        expq.push_back(w(1'b0, 8'hFF, 64'h601));
        expq.push_back(w(1'b1, 8'hFF, 64'h602));
        total++; if (outq.size() - base != 5) $display("FAIL mid_count got=%0d want=5", outq.size() - base); else passed++;
        for (int i = 0; i < 5; i++) begin
            exp_w = expq[i];
            got_w = (base + i < outq.size()) ? outq[base + i] : 73'bx;
            total++; if (got_w !== exp_w) $display("FAIL mid_beat%0d got=%h want=%h", i, got_w, exp_w); else passed++;
        end
        total++; if (good_frames !== 4'd2) $display("FAIL mid_goodcnt_after got=%0d want=2", good_frames); else passed++;
        $display("test_reset_mid done");
    endtask

    task automatic test_saturation();
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 14; i++)
            send_beat(64'h700 + 64'(i), 8'hFF, 1'b1, 1'b0);
        repeat (3) @(posedge rx_clk); #1;
        total++; if (good_frames !== 4'd14) $display("FAIL sat_cnt14 got=%0d want=14", good_frames); else passed++;
        for (int i = 14; i < 17; i++)
            send_beat(64'h700 + 64'(i), 8'hFF, 1'b1, 1'b0);
        repeat (3) @(posedge rx_clk); #1;
        total++; if (good_frames !== 4'hF) $display("FAIL sat_cnt17 got=%0d want=15", good_frames); else passed++;
        $display("test_saturation done");
    endtask

    initial begin
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
